// File: rtl/stream_pkg.sv
// Shared pacer state encoding and underflow-count constants for stream_pacer.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pacer_state_t;

  localparam int UFLOW_COUNT_W = 8;
  localparam logic [UFLOW_COUNT_W-1:0] UFLOW_COUNT_MAX = '1;

  function automatic logic [UFLOW_COUNT_W-1:0] sat_inc(input logic [UFLOW_COUNT_W-1:0] v);
    return (v == UFLOW_COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Circular-buffer FIFO with registered level; head is the oldest stored word (no fall-through).
module stream_fifo #(
  parameter int DATA_SIZE  = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] push_data,
  output logic [DATA_SIZE-1:0] head,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately left unreset; level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/stream_pacer.sv
// Releases buffered words one per PERIOD-cycle slot once the FIFO is primed.
// Optional STREAM_PACER_UNDERFLOW_COUNT_EN adds a saturating underflow_count output.
module stream_pacer
  import stream_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PERIOD      = 8,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_SIZE-1:0]     in_data,
  output logic                     out_valid,
  output logic [DATA_SIZE-1:0]     out_data,
  input  logic                     clear_underflow,
  output logic                     underflow
`ifdef STREAM_PACER_UNDERFLOW_COUNT_EN
  ,
  output logic [UFLOW_COUNT_W-1:0] underflow_count
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(PERIOD);

  pacer_state_t         state_q;
  pacer_state_t         state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [LVL_W-1:0]     level;
  logic [DATA_SIZE-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 uflow_evt;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  stream_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(in_data),
    .head     (head),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  // Dropping enable overrides everything, so a disabled pacer never pops or flags underflow.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    uflow_evt = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          if (level >= LVL_W'(PRIME_LEVEL)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
          if (cnt_q == '0) begin
            if (empty) begin
              uflow_evt = 1'b1;
              state_d   = ST_PRIME;
            end else begin
              pop = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= pop;
      if (pop) out_data <= head;
      if (uflow_evt) underflow <= 1'b1;
      else if (clear_underflow) underflow <= 1'b0;
    end
  end

`ifdef STREAM_PACER_UNDERFLOW_COUNT_EN
  // A clear coinciding with an event restarts the count at one rather than losing the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_count <= '0;
    end else if (clear_underflow) begin
      underflow_count <= uflow_evt ? UFLOW_COUNT_W'(1) : '0;
    end else if (uflow_evt) begin
      underflow_count <= sat_inc(underflow_count);
    end
  end
`endif

endmodule

// File: tb/tb_stream_pacer.sv
// Scoreboard bench for stream_pacer (DATA_SIZE=16, FIFO_DEPTH=4, PERIOD=4, PRIME_LEVEL=2).
module tb_stream_pacer;
  import stream_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int PER   = 4;
  localparam int PRIME = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          clear_underflow;
  logic          underflow;
`ifdef STREAM_PACER_UNDERFLOW_COUNT_EN
  logic [7:0]    underflow_count;
`endif

  int            tests_run    = 0;
  int            tests_failed = 0;
  int            cyc          = 0;
  logic [DW-1:0] exp_q[$];
  int            valid_stamps[$];
  bit            expect_quiet = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_pacer #(
    .DATA_SIZE  (DW),
    .FIFO_DEPTH (DEPTH),
    .PERIOD     (PER),
    .PRIME_LEVEL(PRIME)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .clear_underflow(clear_underflow),
    .underflow      (underflow)
`ifdef STREAM_PACER_UNDERFLOW_COUNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One push handshake on the next edge; the word is queued as an expected output.
  task automatic applyStimulus(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Two words prime the FIFO; both drain on the next two slots and the third slot underflows.
  task automatic underflowRound(input logic [DW-1:0] base);
    applyStimulus(base);
    applyStimulus(base + 16'd1);
    repeat (10) tick();
  endtask

  // Monitor: every out_valid cycle is matched against the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      valid_stamps.push_back(cyc);
      if (expect_quiet) begin
        checkOutput("quiet_out_valid", 32'(out_valid), 32'd0);
      end else if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n           = 1'b0;
    enable          = 1'b0;
    in_valid        = 1'b0;
    in_data         = '0;
    clear_underflow = 1'b0;
    repeat (2) tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Pacing and underflow: pops at push+2 and push+6, underflow slot at push+10.
    valid_stamps.delete();
    enable = 1'b1;
    applyStimulus(16'h0001);
    applyStimulus(16'h0002);
    repeat (9) tick();
    checkOutput("pace_no_uflow_yet", 32'(underflow), 32'd0);
    checkOutput("pace_pulse_count", 32'(valid_stamps.size()), 32'd2);
    if (valid_stamps.size() == 2)
      checkOutput("pace_gap", 32'(valid_stamps[1] - valid_stamps[0]), 32'(PER));
    tick();
    checkOutput("pace_uflow_set", 32'(underflow), 32'd1);
    checkOutput("pace_back_to_prime", 32'(dut.state_q), 32'(ST_PRIME));

    // Asynchronous reset mid-RUN with three words left in the FIFO.
    applyStimulus(16'h00A1);
    applyStimulus(16'h00A2);
    applyStimulus(16'h00A3);
    applyStimulus(16'h00A4);
    checkOutput("prereset_state", 32'(dut.state_q), 32'(ST_RUN));
    checkOutput("prereset_out_valid", 32'(out_valid), 32'd1);
    checkOutput("prereset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_underflow", 32'(underflow), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("release_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Clear on the same edge as an underflow loses to the set; a later clear wins.
    tick();
    applyStimulus(16'h0003);
    applyStimulus(16'h0004);
    repeat (9) tick();
    clear_underflow = 1'b1;
    tick();
    clear_underflow = 1'b0;
    checkOutput("clr_same_edge", 32'(underflow), 32'd1);
    clear_underflow = 1'b1;
    tick();
    clear_underflow = 1'b0;
    checkOutput("clr_later_edge", 32'(underflow), 32'd0);

    // Disabled pacer fills up; the fifth word is refused and nothing is emitted.
    enable = 1'b0;
    tick();
    checkOutput("full_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    expect_quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("full_in_ready", 32'(in_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      if (i < DEPTH) exp_q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full_in_ready_after", 32'(in_ready), 32'd0);
    repeat (6) tick();
    expect_quiet = 1'b0;

    // Steady state: one word per period keeps the pacer fed with no underflow.
    enable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      n = 0;
      while (!in_ready && n < 16) begin
        tick();
        n++;
      end
      checkOutput("steady_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(16'h1000 + 16'(k));
      repeat (3) tick();
    end
    checkOutput("steady_uflow_mid", 32'(underflow), 32'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("steady_drain", 32'(exp_q.size()), 32'd0);
    checkOutput("steady_uflow_end", 32'(underflow), 32'd0);
    n = 0;
    while (!underflow && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drain_uflow", 32'(underflow), 32'd1);

`ifdef STREAM_PACER_UNDERFLOW_COUNT_EN
    clear_underflow = 1'b1;
    tick();
    clear_underflow = 1'b0;
    checkOutput("cnt_cleared", 32'(underflow_count), 32'd0);
    for (int r = 0; r < 3; r++) underflowRound(16'h2000 + 16'(2 * r));
    checkOutput("cnt_three", 32'(underflow_count), 32'd3);
    for (int r = 3; r < 300; r++) underflowRound(16'h2000 + 16'(2 * r));
    checkOutput("cnt_saturate", 32'(underflow_count), 32'd255);
`endif

    repeat (2) tick();
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
